mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle ARM control unit: instruction decoder, main FSM and conditional-execution logic.
//  Sits directly upstream of the datapath and consumes the datapath's Instr and ALUFlags.
//  Drives every datapath select/enable and MemWrite to the unified memory.
//  Supports DP (ADD/SUB/AND/ORR/CMP, reg or imm, optional S), MUL, LDR/STR (imm offset) and B.
// PARAMETERS
//  none; encodings are fixed in mc_defs.vh
// PORTS
//  clk         in   1   system clock, single domain, rising edge
//  reset       in   1   asynchronous, active-high; clears state, Flags and CondExR
//  Instr       in   32  IR contents from the datapath, stable after FETCH
//  ALUFlags    in   4   {N,Z,C,V} from the datapath ALU, valid in EXECR/EXECI
//  PCWrite     out  1   PC register enable
//  RegWrite    out  1   register-file write enable
//  MemWrite    out  1   data-memory write enable
//  IRWrite     out  1   IR enable
//  AdrSrc      out  1   0: PC, 1: Result
//  RegSrc      out  2   [0]=1 selects R15 for RA1 (B); [1]=1 selects Rd for RA2 (STR)
//  ALUSrcA     out  1   0: A, 1: PC
//  ALUSrcB     out  2   00: WriteData, 01: ExtImm, 10: constant 4
//  ResultSrc   out  2   00: ALUOut, 01: Data, 10: ALUResult
//  ImmSrc      out  2   Instr[27:26]: 00 rot-imm8, 01 imm12, 10 branch imm24
//  ALUControl  out  3   000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL
//  opMul       out  1   1 when Instr is MUL (Op=00, I=0, cmd=0000, Instr[7:4]=1001)
// BEHAVIOUR
//  State register (4b), async reset -> FETCH. Outputs are a Moore decode of state, qualified by CondExR.
//   FETCH:  AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 -> DECODE
//   DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (R15=PC+8); CondExR<=CondEx
//     next: Op=01 -> MEMADR; Op=00 & I=1 -> EXECI; Op=00 & I=0 -> EXECR; Op=10 -> BRANCH; Op=11 -> FETCH
//   MEMADR: ALUSrcA=0, ALUSrcB=01, ADD -> MEMRD if L=Instr[20]=1, else MEMWR
//   MEMRD:  AdrSrc=1, ResultSrc=00 -> MEMWB
//   MEMWB:  ResultSrc=01, RegWrite=CondExR -> FETCH
//   MEMWR:  AdrSrc=1, ResultSrc=00, MemWrite=CondExR -> FETCH
//   EXECR:  ALUSrcA=0, ALUSrcB=00, ALUControl from cmd (MUL -> 100) -> ALUWB
//   EXECI:  ALUSrcA=0, ALUSrcB=01, ALUControl from cmd -> ALUWB
//   ALUWB:  ResultSrc=00, RegWrite=CondExR & ~NoWrite -> FETCH
//   BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExR -> FETCH
//  Every output not listed for a state is 0 in that state.
//  All states other than FETCH hold ALUSrcA/ALUSrcB/ALUControl/ResultSrc/AdrSrc at their listed values.
//  Unlisted state codes -> FETCH.
//  Write to R15: in MEMWB/ALUWB with Rd=Instr[15:12]=15, PCWrite=CondExR as well as RegWrite.
//  RegSrc and ImmSrc decode combinationally from Instr in all states.
//  cmd decode: 0100 ADD, 0010 SUB, 0000 AND (or MUL), 1100 ORR, 1010 CMP.
//   CMP = SUB with NoWrite=1 and S forced to 1.
//   Any other cmd: ADD, NoWrite=1, no flag update.
//  FlagW: S=1 ADD/SUB/CMP -> 11; AND/ORR/MUL -> 10. FlagW[1] enables N,Z; FlagW[0] enables C,V.
//  Flags (4b, reset 0) load ALUFlags at the edge that leaves EXECR/EXECI, and only when CondExR=1.
//  CondEx is combinational from Instr[31:28] and Flags, using ARM EQ..AL; 1111 evaluates to 0.
//  CondExR is registered at the DECODE exit edge and has a reset value of 0.
//  Latency, measured in cycles including FETCH:
//   DP/MUL 4 | LDR 5 | STR 4 | B 3 | Op=11 2
//  Reset mid-instruction: abort immediately; state=FETCH, Flags=0, CondExR=0.
//   Outputs show FETCH values while reset is held; datapath registers are held by their own reset.
// STRUCTURE
//  mc_defs.vh: state codes, ALUControl codes, cond codes, Op field codes.
//  Sub-module cond_unit: Flags register, CondEx evaluation, CondExR flop; FlagW/state gating as inputs.
//  Top contains the FSM and the instruction decoder.
// TESTING
//  1 ADD R1,R2,R3 (E0821003): state seq FETCH,DECODE,EXECR,ALUWB.
//    PCWrite=1 only in FETCH; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
//  2 LDR R0,[R1,#4] (E5910004): seq FETCH,DECODE,MEMADR,MEMRD,MEMWB.
//    ImmSrc=01; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB.
//  3 STR R0,[R1,#4] (E5810004): RegSrc=10; MemWrite=1 only in MEMWR; RegWrite never 1.
//  4 SUBS R0,R0,R0 (E0500000), ALUFlags=0110 in EXECR -> Flags=0110.
//    Then BEQ (0A000002) -> PCWrite=1 in BRANCH; BNE (1A000002) -> PCWrite=0 in BRANCH.
//  5 MUL R0,R1,R2 (E0000291): opMul=1 from DECODE onward; ALUControl=100 in EXECR; RegWrite=1 in ALUWB.
//  6 ADDNE with Z=1 -> RegWrite=0 in ALUWB and Flags unchanged.
//    Reset asserted during MEMRD -> state=FETCH, Flags=0000, MemWrite=0, next instr fetched after release.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states,
// instruction field codes, ALU controls, condition codes and the
// registered control-word layout.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // Op field, Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // DP cmd field, Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    // ARM condition field, Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Registered datapath controls; RegSrc/ImmSrc/opMul are not here
    // because they follow Instr combinationally.
    typedef struct packed {
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

    // FETCH: IR <= Mem[PC], PC <= PC + 4
    localparam ctrl_t CTRL_FETCH = '{
        pc_write:    1'b1,
        reg_write:   1'b0,
        mem_write:   1'b0,
        ir_write:    1'b1,
        adr_src:     1'b0,
        alu_src_a:   1'b1,
        alu_src_b:   2'b10,
        result_src:  2'b10,
        alu_control: ALU_ADD
    };

    // Evaluate an ARM condition against {N,Z,C,V}; the 1111 code never executes
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_cond_unit.sv
// Conditional-execution unit: holds the NZCV flags, evaluates the
// instruction condition and latches the verdict for the rest of the
// instruction.
module mc_controller_cond_unit
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       flags_en,
    input  logic       capture_en,
    output logic       cond_ex,
    output logic       cond_ex_r
);

    logic [3:0] flags;

    // Condition verdict from the live flags, consumed during DECODE
    always_comb begin
        cond_ex = cond_eval(cond, flags);
    end

    // Flags load on the execute-exit edge of an executing instruction; verdict latches on DECODE exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags     <= 4'b0000;
            cond_ex_r <= 1'b0;
        end else begin
            if (capture_en) begin
                cond_ex_r <= cond_ex;
            end
            if (flags_en && cond_ex_r) begin
                if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
                if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: instruction decoder plus main FSM. The
// datapath controls are registered alongside the state so they come
// straight out of flops as a Moore decode of the current state.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        opMul
);

    state_t     state, state_n;
    ctrl_t      ctrl_q, ctrl_n;

    logic [1:0] op;
    logic       imm;
    logic [3:0] cmd;
    logic       sbit;
    logic       rd_pc;
    logic [2:0] alu_dp;
    logic       no_write;
    logic [1:0] flag_w;
    logic       cond_ex;
    logic       cond_ex_r;
    logic       cond_ok;
    logic       unused_instr_bits;

    assign op    = Instr[27:26];
    assign imm   = Instr[25];
    assign cmd   = Instr[24:21];
    assign sbit  = Instr[20];
    assign rd_pc = (Instr[15:12] == 4'hF);

    // Register numbers and offset bits belong to the datapath only
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

    assign opMul  = (op == OP_DP) && !imm && (cmd == CMD_AND) && (Instr[7:4] == 4'b1001);
    assign RegSrc = {(op == OP_MEM) && !sbit, (op == OP_BR)};
    assign ImmSrc = op;

    // DP decode: ALU operation, suppressed writeback and flag-write enables
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        alu_dp   = ALU_ADD;
        no_write = 1'b0;
        flag_w   = 2'b00;
        case (cmd)
            CMD_ADD: begin
                alu_dp = ALU_ADD;
                flag_w = sbit ? 2'b11 : 2'b00;
            end
            CMD_SUB: begin
                alu_dp = ALU_SUB;
                flag_w = sbit ? 2'b11 : 2'b00;
            end
            CMD_AND: begin
                alu_dp = opMul ? ALU_MUL : ALU_AND;
                flag_w = sbit ? 2'b10 : 2'b00;
            end
            CMD_ORR: begin
                alu_dp = ALU_ORR;
                flag_w = sbit ? 2'b10 : 2'b00;
            end
            CMD_CMP: begin
                alu_dp   = ALU_SUB;
                no_write = 1'b1;
                flag_w   = 2'b11;
            end
            default: begin
                alu_dp   = ALU_ADD;
                no_write = 1'b1;
            end
        endcase
    end

    mc_controller_cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (Instr[31:28]),
        .alu_flags  (ALUFlags),
        .flag_w     (flag_w),
        .flags_en   ((state == S_EXECR) || (state == S_EXECI)),
        .capture_en (state == S_DECODE),
        .cond_ex    (cond_ex),
        .cond_ex_r  (cond_ex_r)
    );

    // Next state and the control word that state will present
    always_comb begin
        // Leaving DECODE the latched verdict is not there yet, so use the live one
        cond_ok = (state == S_DECODE) ? cond_ex : cond_ex_r;

        state_n = S_FETCH;
        case (state)
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_n = S_MEMADR;
                    OP_DP:   state_n = imm ? S_EXECI : S_EXECR;
                    OP_BR:   state_n = S_BRANCH;
                    default: state_n = S_FETCH;
                endcase
            end
            S_MEMADR: state_n = sbit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_n = S_MEMWB;
            S_EXECR:  state_n = S_ALUWB;
            S_EXECI:  state_n = S_ALUWB;
            default:  state_n = S_FETCH;
        endcase

        ctrl_n = '0;
        case (state_n)
            S_DECODE: begin
                ctrl_n.alu_src_a  = 1'b1;
                ctrl_n.alu_src_b  = 2'b10;
                ctrl_n.result_src = 2'b10;
            end
            S_MEMADR: begin
                ctrl_n.alu_src_b = 2'b01;
            end
            S_MEMRD: begin
                ctrl_n.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl_n.result_src = 2'b01;
                ctrl_n.reg_write  = cond_ok;
                ctrl_n.pc_write   = cond_ok && rd_pc;
            end
            S_MEMWR: begin
                ctrl_n.adr_src   = 1'b1;
                ctrl_n.mem_write = cond_ok;
            end
            S_EXECR: begin
                ctrl_n.alu_control = alu_dp;
            end
            S_EXECI: begin
                ctrl_n.alu_src_b   = 2'b01;
                ctrl_n.alu_control = alu_dp;
            end
            S_ALUWB: begin
                ctrl_n.reg_write = cond_ok && !no_write;
                ctrl_n.pc_write  = cond_ok && !no_write && rd_pc;
            end
            S_BRANCH: begin
                ctrl_n.alu_src_b  = 2'b01;
                ctrl_n.result_src = 2'b10;
                ctrl_n.pc_write   = cond_ok;
            end
            default: ctrl_n = CTRL_FETCH;
        endcase
    end

    // State and registered controls; reset aborts to FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state  <= S_FETCH;
            ctrl_q <= CTRL_FETCH;
        end else begin
            state  <= state_n;
            ctrl_q <= ctrl_n;
        end
    end

    assign PCWrite    = ctrl_q.pc_write;
    assign RegWrite   = ctrl_q.reg_write;
    assign MemWrite   = ctrl_q.mem_write;
    assign IRWrite    = ctrl_q.ir_write;
    assign AdrSrc     = ctrl_q.adr_src;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign ResultSrc  = ctrl_q.result_src;
    assign ALUControl = ctrl_q.alu_control;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: acts as the datapath (IR loads on the FETCH
// edge), steps a table of instructions through the FSM and compares the
// whole control vector every cycle against a scoreboard of expected words.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, opMul;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .opMul      (opMul)
    );

    always #5 clk = ~clk;

    // Bench-side state names
    localparam logic [3:0] T_F = 4'd0, T_D = 4'd1, T_MA = 4'd2, T_MR = 4'd3, T_MW = 4'd4,
                           T_MWR = 4'd5, T_ER = 4'd6, T_EI = 4'd7, T_AW = 4'd8, T_BR = 4'd9;
    // Instruction classes
    localparam logic [2:0] K_DPR = 3'd0, K_DPI = 3'd1, K_LDR = 3'd2, K_STR = 3'd3,
                           K_B = 3'd4, K_UND = 3'd5;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  alu_flags;
        logic [2:0]  kind;
        logic        cond;
        logic [3:0]  exp_flags;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    logic [31:0] cur_instr;
    logic [17:0] exp_q[$];
    vec_t        vecs[19];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, want);
        end
    endtask

    // Expected control word for a state, from the state table
    function automatic logic [17:0] exp_out(input logic [3:0] st, input logic [31:0] ins,
                                            input logic condr);
        logic [1:0] op;
        logic [3:0] cmd;
        logic       mul, nowrite, rd15, pcw, rw, mw, irw, adr, sa;
        logic [1:0] sb, rs, regsrc;
        logic [2:0] ac, aluc;
        op   = ins[27:26];
        cmd  = ins[24:21];
        rd15 = (ins[15:12] == 4'hF);
        mul  = (op == 2'b00) && !ins[25] && (cmd == 4'b0000) && (ins[7:4] == 4'b1001);
        regsrc = {(op == 2'b01) && !ins[20], op == 2'b10};
        nowrite = 1'b0;
        case (cmd)
            4'b0100: aluc = 3'b000;
            4'b0010: aluc = 3'b001;
            4'b0000: aluc = mul ? 3'b100 : 3'b010;
            4'b1100: aluc = 3'b011;
            4'b1010: begin aluc = 3'b001; nowrite = 1'b1; end
            default: begin aluc = 3'b000; nowrite = 1'b1; end
        endcase
        {pcw, rw, mw, irw, adr, sa} = 6'b0;
        sb = 2'b00; rs = 2'b00; ac = 3'b000;
        case (st)
            T_F:   begin pcw = 1; irw = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
            T_D:   begin sa = 1; sb = 2'b10; rs = 2'b10; end
            T_MA:  sb = 2'b01;
            T_MR:  adr = 1;
            T_MW:  begin rs = 2'b01; rw = condr; pcw = condr & rd15; end
            T_MWR: begin adr = 1; mw = condr; end
            T_ER:  ac = aluc;
            T_EI:  begin sb = 2'b01; ac = aluc; end
            T_AW:  begin rw = condr & ~nowrite; pcw = condr & ~nowrite & rd15; end
            T_BR:  begin sb = 2'b01; rs = 2'b10; pcw = condr; end
            default: ;
        endcase
        return {pcw, rw, mw, irw, adr, regsrc, sa, sb, rs, ins[27:26], ac, mul};
    endfunction

    // Pop the oldest expectation and compare against the DUT's current outputs
    task automatic compare_pop(input string name);
        logic [17:0] want;
        logic [17:0] got;
        if (exp_q.size() == 0) begin
            check({name, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            want = exp_q.pop_front();
            got  = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
                    ResultSrc, ImmSrc, ALUControl, opMul};
            check(name, {14'd0, got}, {14'd0, want});
        end
    endtask

    // Drive one cycle: queue the expectation, check mid-cycle, advance past the edge
    task automatic step(input string name, input logic [3:0] st, input logic [31:0] ins,
                        input logic condr);
        exp_q.push_back(exp_out(st, ins, condr));
        @(negedge clk);
        compare_pop(name);
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH to its last state; IR loads on the FETCH edge
    task automatic run_instr(input int idx, input vec_t v);
        logic [3:0] seq[5];
        int len;
        case (v.kind)
            K_DPR:   begin seq = '{T_F, T_D, T_ER, T_AW, T_F};  len = 4; end
            K_DPI:   begin seq = '{T_F, T_D, T_EI, T_AW, T_F};  len = 4; end
            K_LDR:   begin seq = '{T_F, T_D, T_MA, T_MR, T_MW}; len = 5; end
            K_STR:   begin seq = '{T_F, T_D, T_MA, T_MWR, T_F}; len = 4; end
            K_B:     begin seq = '{T_F, T_D, T_BR, T_F, T_F};   len = 3; end
            default: begin seq = '{T_F, T_D, T_F, T_F, T_F};    len = 2; end
        endcase
        ALUFlags = v.alu_flags;
        for (int k = 0; k < len; k++) begin
            if (k == 0) begin
                step($sformatf("v%0d_fetch", idx), T_F, cur_instr, 1'b0);
                Instr     = v.instr;
                cur_instr = v.instr;
            end else begin
                step($sformatf("v%0d_cyc%0d", idx, k), seq[k], v.instr, v.cond);
            end
        end
        check($sformatf("v%0d_flags", idx), {28'd0, dut.u_cond.flags}, {28'd0, v.exp_flags});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             instr          aluflags kind   cond  flags after
        vecs[0]  = '{32'hE0821003, 4'b1111, K_DPR, 1'b1, 4'b0000}; // ADD
        vecs[1]  = '{32'hE5910004, 4'b1111, K_LDR, 1'b1, 4'b0000}; // LDR
        vecs[2]  = '{32'hE5810004, 4'b1111, K_STR, 1'b1, 4'b0000}; // STR
        vecs[3]  = '{32'hE0500000, 4'b0110, K_DPR, 1'b1, 4'b0110}; // SUBS
        vecs[4]  = '{32'h0A000002, 4'b0000, K_B,   1'b1, 4'b0110}; // BEQ taken
        vecs[5]  = '{32'h1A000002, 4'b0000, K_B,   1'b0, 4'b0110}; // BNE not taken
        vecs[6]  = '{32'hE0000291, 4'b1001, K_DPR, 1'b1, 4'b0110}; // MUL
        vecs[7]  = '{32'h10921003, 4'b1001, K_DPR, 1'b0, 4'b0110}; // ADDSNE, Z=1
        vecs[8]  = '{32'hEC000000, 4'b1111, K_UND, 1'b1, 4'b0110}; // Op=11
        vecs[9]  = '{32'hE2911001, 4'b1001, K_DPI, 1'b1, 4'b1001}; // ADDS imm
        vecs[10] = '{32'hE0121003, 4'b0110, K_DPR, 1'b1, 4'b0101}; // ANDS: NZ only
        vecs[11] = '{32'hE1500001, 4'b1000, K_DPR, 1'b1, 4'b1000}; // CMP
        vecs[12] = '{32'hE0321003, 4'b0111, K_DPR, 1'b1, 4'b1000}; // EORS: unsupported
        vecs[13] = '{32'hF0921003, 4'b0111, K_DPR, 1'b0, 4'b1000}; // cond 1111
        vecs[14] = '{32'hE082F003, 4'b0000, K_DPR, 1'b1, 4'b1000}; // ADD to R15
        vecs[15] = '{32'hBA000002, 4'b0000, K_B,   1'b1, 4'b1000}; // BLT taken
        vecs[16] = '{32'hAA000002, 4'b0000, K_B,   1'b0, 4'b1000}; // BGE not taken
        vecs[17] = '{32'hE5910004, 4'b1111, K_LDR, 1'b1, 4'b1000}; // LDR (aborted)
        vecs[18] = '{32'hE0821003, 4'b1111, K_DPR, 1'b1, 4'b0000}; // ADD after reset

        reset     = 1'b1;
        Instr     = 32'h0;
        ALUFlags  = 4'h0;
        cur_instr = 32'h0;

        // Reset state: FETCH controls, cleared flags and verdict
        @(posedge clk);
        step("reset_outputs", T_F, cur_instr, 1'b0);
        check("reset_flags", {28'd0, dut.u_cond.flags}, 32'd0);
        check("reset_condexr", {31'd0, dut.u_cond.cond_ex_r}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_instr(i, vecs[i]);
        end

        // Reset asserted during MEMRD of a load
        ALUFlags = vecs[17].alu_flags;
        step("rst_fetch", T_F, cur_instr, 1'b0);
        Instr     = vecs[17].instr;
        cur_instr = vecs[17].instr;
        step("rst_decode", T_D,  cur_instr, 1'b1);
        step("rst_memadr", T_MA, cur_instr, 1'b1);
        exp_q.push_back(exp_out(T_MR, cur_instr, 1'b1));
        @(negedge clk);
        compare_pop("rst_memrd");
        reset = 1'b1;
        #1;
        exp_q.push_back(exp_out(T_F, cur_instr, 1'b0));
        compare_pop("rst_abort_outputs");
        check("rst_abort_flags", {28'd0, dut.u_cond.flags}, 32'd0);
        check("rst_abort_condexr", {31'd0, dut.u_cond.cond_ex_r}, 32'd0);
        check("rst_abort_memwrite", {31'd0, MemWrite}, 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(exp_out(T_F, cur_instr, 1'b0));
        compare_pop("rst_held_outputs");
        reset = 1'b0;

        // Next instruction is fetched normally after release
        run_instr(18, vecs[18]);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
